line_bus_bridge: RTL
====================

// Module: line_bus_bridge
// PURPOSE
//  Downstream neighbour of the core's data cache: converts a 256-bit cache-line read/write request
//  (ram_read_op/ram_write_op/ram_addr/ram_data_o/ram_data_i side of core) into eight sequential
//  32-bit word transfers on the external memory bus with req/ack handshake. Single clock domain.
//  Returns a one-cycle line_done so data_cache can drop busy.
// PARAMETERS
//  ADDR_W     32   byte-address width, both sides
//  WORD_W     32   external bus data width
//  LINE_WORDS 8    words per line; LINE_W = WORD_W*LINE_WORDS = 256
// PORTS
//  CLK         in   1        clock, rising edge
//  RST         in   1        reset, asynchronous, active-low
//  line_read   in   1        line-fill request (level, from cache ram_read_op)
//  line_write  in   1        line-writeback request (level, from cache ram_write_op)
//  line_addr   in   ADDR_W   line byte address; bits [4:0] ignored
//  line_wdata  in   LINE_W   writeback data; word k = bits [32k+31:32k]
//  line_rdata  out  LINE_W   fill data (to cache ram_data_i), word k at [32k+31:32k]
//  line_done   out  1        one-cycle pulse: transfer complete
//  bus_req     out  1        word transfer request
//  bus_we      out  1        1 = write beat, 0 = read beat
//  bus_addr    out  ADDR_W   word byte address, bits [1:0] = 0
//  bus_wdata   out  WORD_W   write beat data
//  bus_rdata   in   WORD_W   read beat data, valid in the ack cycle
//  bus_ack     in   1        beat accepted/completed this cycle
// BEHAVIOUR
//  Reset (RST=0, async): state=IDLE, beat=0, all outputs 0 incl. line_rdata; bus_req drops at once.
//  FSM states IDLE, XFER, DONE (encodings in config.vh). All outputs registered.
//  IDLE: if line_write -> latch base={line_addr[31:5],5'b0}, latch line_wdata, we=1, beat=0, XFER.
//    else if line_read -> latch base, we=0, beat=0, XFER. Write wins if both high.
//  XFER: bus_req=1, bus_we=we, bus_addr=base+4*beat, bus_wdata=word[beat]; all stable until ack.
//    On bus_ack: read -> line_rdata[beat] <= bus_rdata; if beat==LINE_WORDS-1 -> DONE,
//    else beat+1, next beat presented the following cycle (bus_req stays 1, no idle gap).
//    bus_ack while bus_req=0 is ignored. No timeout: waits indefinitely for ack.
//  DONE: bus_req=0, line_done=1 for exactly this cycle, then IDLE. Request inputs ignored in DONE;
//    requester deasserts its op the cycle after seeing line_done. Op still high in IDLE = new request.
//  line_rdata: updated word-by-word during a read; full line valid from DONE cycle and held until
//    the next read's first ack. Writes never modify line_rdata.
//  Request inputs/line_addr/line_wdata are sampled only in IDLE; changes during XFER have no effect.
//  Latency, zero-wait bus (ack in first req cycle): request seen cycle 0, beats cycles 1..8,
//    line_done cycle 9. Each extra wait cycle adds one. Address wrap at 2^ADDR_W is modulo.
//  Reset mid-transfer: transfer abandoned, no line_done, line_rdata cleared.
// STRUCTURE
//  config.vh: `LINE_WIDTH 255:0, `LINE_WORDS 8, `BEAT_WIDTH 2:0, BRIDGE_IDLE/XFER/DONE codes.
//  Single module; no sub-module is natural (counter + 3-state FSM + line register).
// TESTING
//  Read, zero-wait: line_addr=0x1000_0013, memory word k=0xA0+k -> bus_addr 0x1000_0000..0x1C,
//    line_rdata word k = 0xA0+k, line_done at cycle 9, single pulse.
//  Write, 2 wait cycles/beat: line_wdata word k=0x1111_0000+k, addr 0x200 -> 8 write beats,
//    bus_wdata/addr stable through waits, line_done at cycle 25; line_rdata unchanged.
//  line_read & line_write both high in IDLE -> write beats (bus_we=1), no read performed.
//  RST low during beat 4 of a read -> bus_req=0 same cycle, line_rdata=0, no line_done,
//    after release state IDLE and next read completes normally.
//  Back-to-back: op held high through DONE -> one idle cycle, then second transfer starts;
//    spurious bus_ack with bus_req=0 in IDLE/DONE -> no effect.
//  Address wrap: line_addr=0xFFFF_FFE0 read -> last bus_addr 0xFFFF_FFFC, no carry into state.

Source files
------------

// File: rtl/line_bus_bridge_pkg.sv
// Shared constants for the cache-line to word-bus bridge: bus widths, beat count and FSM codes.
package line_bus_bridge_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned LINE_WORDS = 8;
    localparam int unsigned LINE_W     = WORD_W * LINE_WORDS;
    localparam int unsigned BEAT_W     = 3;

    localparam logic [1:0] BRIDGE_IDLE = 2'd0;
    localparam logic [1:0] BRIDGE_XFER = 2'd1;
    localparam logic [1:0] BRIDGE_DONE = 2'd2;

    typedef logic [BEAT_W-1:0] beat_t;

    localparam beat_t LAST_BEAT = beat_t'(LINE_WORDS - 1);

    // Word k of a line occupies bits [32k+31:32k].
    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input beat_t             idx);
        return line[{idx, 5'b00000} +: WORD_W];
    endfunction

endpackage

// File: rtl/line_bus_bridge.sv
// Splits a 256-bit cache-line read or write into eight 32-bit req/ack beats on the external bus
// and pulses line_done for one cycle when the line is complete. All outputs are registered.
module line_bus_bridge
    import line_bus_bridge_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [ADDR_W-1:0] line_addr,
    input  logic [LINE_W-1:0] line_wdata,
    output logic [LINE_W-1:0] line_rdata,
    output logic              line_done,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [WORD_W-1:0] bus_wdata,
    input  logic [WORD_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    logic [1:0]        state_q, state_d;
    beat_t             beat_q, beat_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] bwdata_q, bwdata_d;
    beat_t             beat_nxt;

    // The low five address bits select a byte within the line and are deliberately dropped.
    logic unused_line_offset;
    assign unused_line_offset = ^line_addr[4:0];

    assign beat_nxt = beat_q + beat_t'(1);

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        req_d    = req_q;
        we_d     = we_q;
        done_d   = 1'b0;
        addr_d   = addr_q;
        bwdata_d = bwdata_q;

        case (state_q)
            BRIDGE_IDLE: begin
                if (line_write || line_read) begin
                    state_d  = BRIDGE_XFER;
                    beat_d   = '0;
                    req_d    = 1'b1;
                    we_d     = line_write;
                    wdata_d  = line_wdata;
                    addr_d   = {line_addr[ADDR_W-1:5], 5'b00000};
                    bwdata_d = line_write ? line_word(line_wdata, '0) : '0;
                end
            end
            BRIDGE_XFER: begin
                if (bus_ack) begin
                    if (!we_q) begin
                        rdata_d[{beat_q, 5'b00000} +: WORD_W] = bus_rdata;
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_d  = BRIDGE_DONE;
                        req_d    = 1'b0;
                        we_d     = 1'b0;
                        done_d   = 1'b1;
                        addr_d   = '0;
                        bwdata_d = '0;
                    end else begin
                        // Beat index sits below the line base, so the word address never carries.
                        beat_d   = beat_nxt;
                        addr_d   = {addr_q[ADDR_W-1:5], beat_nxt, 2'b00};
                        bwdata_d = we_q ? line_word(wdata_q, beat_nxt) : '0;
                    end
                end
            end
            BRIDGE_DONE: begin
                state_d = BRIDGE_IDLE;
            end
            default: begin
                state_d = BRIDGE_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= BRIDGE_IDLE;
            beat_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            addr_q   <= '0;
            bwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            req_q    <= req_d;
            we_q     <= we_d;
            done_q   <= done_d;
            addr_q   <= addr_d;
            bwdata_q <= bwdata_d;
        end
    end

    assign line_rdata = rdata_q;
    assign line_done  = done_q;
    assign bus_req    = req_q;
    assign bus_we     = we_q;
    assign bus_addr   = addr_q;
    assign bus_wdata  = bwdata_q;

endmodule
